// File: rtl/reducer_pkg.sv
// -----------------------------------------------------------------------------
// reducer_pkg
// Shared types for the operand_reducer slice.
//   mode_e  : reduction operation select (add / subtract / unsigned min / max)
//   state_e : sequencing states of the reducer FSM
// No ports.
// -----------------------------------------------------------------------------
package reducer_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_MIN = 2'b10,
    MODE_MAX = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reducer_alu.sv
// -----------------------------------------------------------------------------
// reducer_alu
// Purely combinational step function of the reducer: f(acc, operand, mode).
// Add/subtract wrap modulo 2^WIDTH; min/max compare unsigned.
// Optional feature macro: REDUCER_OVF_EN -- when defined, o_carry reports the
// add carry-out / subtract borrow of this step (0 for min/max); when undefined
// the o_carry port and all carry logic are absent.
// Ports:
//   i_acc     in  WIDTH  running accumulator
//   i_operand in  WIDTH  next operand
//   i_mode    in  mode_e operation select
//   o_result  out WIDTH  step result
//   o_carry   out 1      carry/borrow of this step (REDUCER_OVF_EN only)
// -----------------------------------------------------------------------------
module reducer_alu
  import reducer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_operand,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_result
`ifdef REDUCER_OVF_EN
  ,
  output logic             o_carry
`endif
);

  always_comb begin
    o_result = i_acc;
`ifdef REDUCER_OVF_EN
    o_carry  = 1'b0;
`endif
    case (i_mode)
`ifdef REDUCER_OVF_EN
      // One extra bit catches the carry; for subtraction it becomes 1 exactly
      // when the difference wraps (borrow).
      MODE_ADD: {o_carry, o_result} = {1'b0, i_acc} + {1'b0, i_operand};
      MODE_SUB: {o_carry, o_result} = {1'b0, i_acc} - {1'b0, i_operand};
`else
      MODE_ADD: o_result = i_acc + i_operand;
      MODE_SUB: o_result = i_acc - i_operand;
`endif
      MODE_MIN: o_result = (i_operand < i_acc) ? i_operand : i_acc;
      MODE_MAX: o_result = (i_operand > i_acc) ? i_operand : i_acc;
      default:  o_result = i_acc;
    endcase
  end

endmodule

// File: rtl/operand_reducer.sv
// -----------------------------------------------------------------------------
// operand_reducer
// Folds NUM_OPS packed WIDTH-bit operands into one result, one operand per
// clock, using the operation captured at start. Result appears on out with a
// one-cycle valid pulse; busy covers RUN and DONE.
// Optional feature macro: REDUCER_OVF_EN -- sticky carry/borrow flag on ovf;
// when undefined ovf is tied low.
// Ports:
//   clk    in  1               rising-edge clock
//   reset  in  1               asynchronous active-high reset
//   inputs in  WIDTH*NUM_OPS   packed operands, operand 0 in the LSBs
//   mode   in  2               00 add, 01 sub, 10 unsigned min, 11 unsigned max
//   start  in  1               request, sampled only in IDLE
//   busy   out 1               high in RUN and DONE
//   out    out WIDTH           registered result, held until next DONE/reset
//   valid  out 1               one-cycle pulse with a new result
//   ovf    out 1               carry/borrow seen during the current result
// -----------------------------------------------------------------------------
module operand_reducer
  import reducer_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_OPS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH*NUM_OPS-1:0] inputs,
  input  logic [1:0]               mode,
  input  logic                     start,
  output logic                     busy,
  output logic [WIDTH-1:0]         out,
  output logic                     valid,
  output logic                     ovf
);

  localparam int unsigned      IW       = $clog2(NUM_OPS + 1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_OPS - 1);

  state_e                   r_state;
  state_e                   w_next_state;
  mode_e                    r_mode;
  logic [WIDTH*NUM_OPS-1:0] r_inputs;
  logic [WIDTH-1:0]         r_acc;
  logic [IW-1:0]            r_idx;
  logic [WIDTH-1:0]         r_out;

  logic [WIDTH-1:0]         w_ops [NUM_OPS];
  logic [WIDTH-1:0]         w_operand;
  logic [WIDTH-1:0]         w_result;
  logic                     w_last;

`ifdef REDUCER_OVF_EN
  logic                     w_carry;
  logic                     r_carry;  // sticky carry across steps in flight
  logic                     r_ovf;    // published with out
`endif

  // Unpack the captured word so the operand mux indexes a plain array.
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_unpack
    assign w_ops[k] = r_inputs[k*WIDTH +: WIDTH];
  end

  always_comb begin
    w_operand = w_ops[0];
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      if (r_idx == IW'(k)) begin
        w_operand = w_ops[k];
      end
    end
  end

  assign w_last = (r_idx == LAST_IDX);

  reducer_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_acc     (r_acc),
    .i_operand (w_operand),
    .i_mode    (r_mode),
    .o_result  (w_result)
`ifdef REDUCER_OVF_EN
    ,
    .o_carry   (w_carry)
`endif
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (NUM_OPS > 1) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (r_state != IDLE);
    valid = (r_state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_ADD;
      r_inputs <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_out    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode   <= mode_e'(mode);
            r_inputs <= inputs;
            r_acc    <= inputs[WIDTH-1:0];
            r_idx    <= IW'(1);
            if (NUM_OPS == 1) begin
              r_out <= inputs[WIDTH-1:0];
            end
          end
        end
        RUN: begin
          r_acc <= w_result;
          r_idx <= r_idx + IW'(1);
          if (w_last) begin
            r_out <= w_result;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REDUCER_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        RUN: begin
          r_carry <= r_carry | w_carry;
          // Include this step's carry directly so the flag lands with out.
          if (w_last) begin
            r_ovf <= r_carry | w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign out = r_out;

endmodule

// File: tb/tb_operand_reducer.sv
// -----------------------------------------------------------------------------
// tb_operand_reducer
// Self-checking bench for operand_reducer: a default instance (WIDTH=4,
// NUM_OPS=6) and a single-operand instance (WIDTH=8, NUM_OPS=1).
// Expected ovf follows REDUCER_OVF_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_operand_reducer;

  logic        clk;
  logic        reset;
  logic [23:0] inputs;
  logic [1:0]  mode;
  logic        start;
  logic        busy;
  logic [3:0]  out;
  logic        valid;
  logic        ovf;

  logic [7:0]  inputs8;
  logic [1:0]  mode8;
  logic        start8;
  logic        busy8;
  logic [7:0]  out8;
  logic        valid8;
  logic        ovf8;

  int n_err;
  int n_checks;

  operand_reducer dut (
    .clk    (clk),
    .reset  (reset),
    .inputs (inputs),
    .mode   (mode),
    .start  (start),
    .busy   (busy),
    .out    (out),
    .valid  (valid),
    .ovf    (ovf)
  );

  operand_reducer #(
    .WIDTH   (8),
    .NUM_OPS (1)
  ) dut1 (
    .clk    (clk),
    .reset  (reset),
    .inputs (inputs8),
    .mode   (mode8),
    .start  (start8),
    .busy   (busy8),
    .out    (out8),
    .valid  (valid8),
    .ovf    (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: reduction of six 4-bit operands from whole-sequence arithmetic.
  // A running sum wraps at least once iff the true total reaches 16; a left-fold
  // difference borrows iff the operands after op0 add up to more than op0.
  function automatic void model(input logic [23:0] ops, input int md,
                                output int res, output int ov);
    int op[6];
    int total;
    int rest;
    total = 0;
    for (int k = 0; k < 6; k++) begin
      op[k] = int'((ops >> (4 * k)) & 24'hF);
      total += op[k];
    end
    rest = total - op[0];
    res  = op[0];
    ov   = 0;
    case (md)
      0: begin
        res = total % 16;
        ov  = (total >= 16) ? 1 : 0;
      end
      1: begin
        res = ((op[0] - rest) % 16 + 16) % 16;
        ov  = (rest > op[0]) ? 1 : 0;
      end
      2: for (int k = 1; k < 6; k++) if (op[k] < res) res = op[k];
      default: for (int k = 1; k < 6; k++) if (op[k] > res) res = op[k];
    endcase
`ifndef REDUCER_OVF_EN
    ov = 0;
`endif
  endfunction

  // One start pulse; inputs/mode scrambled after E0. Checks latency, result,
  // flag, single-cycle valid and that out holds afterwards.
  task automatic run_op(input logic [23:0] ops, input logic [1:0] md, input string tag,
                        output logic [3:0] o_res, output logic o_ov);
    int exp_res;
    int exp_ov;
    int edges;
    model(ops, int'(md), exp_res, exp_ov);
    @(negedge clk);
    inputs = ops;
    mode   = md;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    inputs = 24'($urandom);
    mode   = 2'($urandom);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    edges = 0;
    while (valid !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
      inputs = 24'($urandom);
      mode   = 2'($urandom);
    end
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'd5);
    check({tag, "_out"}, 32'(out), 32'(exp_res));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ov));
    o_res = out;
    o_ov  = ovf;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(valid), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_out_hold"}, 32'(out), 32'(exp_res));
  endtask

  logic [3:0]  r4;
  logic        rov;
  logic [23:0] ops_q [3];
  logic [1:0]  md_q  [3];
  int          e_res;
  int          e_ov;
  int          early;
  int          seen;
  logic [7:0]  v8;

  localparam logic [23:0] VEC = 24'h153C26;  // op0=6 op1=2 op2=12 op3=3 op4=5 op5=1
`ifdef REDUCER_OVF_EN
  localparam int ADDSUB_OVF = 1;
`else
  localparam int ADDSUB_OVF = 0;
`endif

  initial begin
    n_err    = 0;
    n_checks = 0;
    reset    = 1'b1;
    start    = 1'b0;
    inputs   = '0;
    mode     = '0;
    start8   = 1'b0;
    inputs8  = '0;
    mode8    = '0;

    // Reset state before any clock edge.
    #3;
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_out8", 32'(out8), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector, all four modes.
    run_op(VEC, 2'b00, "add", r4, rov);
    check("add_const_out", 32'(r4), 32'd13);
    check("add_const_ovf", 32'(rov), 32'(ADDSUB_OVF));
    run_op(VEC, 2'b01, "sub", r4, rov);
    check("sub_const_out", 32'(r4), 32'd15);
    check("sub_const_ovf", 32'(rov), 32'(ADDSUB_OVF));
    run_op(VEC, 2'b10, "min", r4, rov);
    check("min_const_out", 32'(r4), 32'd1);
    check("min_const_ovf", 32'(rov), 32'd0);
    run_op(VEC, 2'b11, "max", r4, rov);
    check("max_const_out", 32'(r4), 32'd12);
    check("max_const_ovf", 32'(rov), 32'd0);

    // Reset two cycles into a run: asynchronous clear, no valid afterwards.
    @(negedge clk);
    inputs = VEC;
    mode   = 2'b00;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    #1;
    check("midrst_out_async", 32'(out), 32'd0);
    check("midrst_busy_async", 32'(busy), 32'd0);
    check("midrst_valid_async", 32'(valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid === 1'b1) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    check("midrst_out_zero", 32'(out), 32'd0);
    run_op(VEC, 2'b11, "post_rst_max", r4, rov);
    check("post_rst_const_out", 32'(r4), 32'd12);

    // Randomized operations against the reference.
    for (int n = 0; n < 25; n++) begin
      run_op(24'($urandom), 2'($urandom_range(0, 3)), "rand", r4, rov);
    end

    // Start held high: each capture exactly seven cycles apart.
    for (int n = 0; n < 3; n++) begin
      ops_q[n] = 24'($urandom);
      md_q[n]  = 2'($urandom_range(0, 3));
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (n > 0) check("hold_valid_gap", 32'(valid), 32'd0);
      inputs = ops_q[n];
      mode   = md_q[n];
      start  = 1'b1;
      model(ops_q[n], int'(md_q[n]), e_res, e_ov);
      early = 0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c < 6 && valid === 1'b1) early++;
        inputs = 24'($urandom);
        mode   = 2'($urandom);
        if (c == 6) begin
          check("hold_early_valid", 32'(early), 32'd0);
          check("hold_valid", 32'(valid), 32'd1);
          check("hold_out", 32'(out), 32'(e_res));
          check("hold_ovf", 32'(ovf), 32'(e_ov));
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("hold_end_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("hold_end_busy", 32'(busy), 32'd0);

    // Single-operand instance: result one cycle after E0.
    for (int n = 0; n < 4; n++) begin
      v8 = (n == 0) ? 8'hA5 : 8'($urandom);
      @(negedge clk);
      inputs8 = v8;
      mode8   = 2'($urandom_range(0, 3));
      start8  = 1'b1;
      @(negedge clk);
      start8  = 1'b0;
      inputs8 = 8'($urandom);
      check("one_valid", 32'(valid8), 32'd1);
      check("one_busy", 32'(busy8), 32'd1);
      check("one_out", 32'(out8), 32'(v8));
      check("one_ovf", 32'(ovf8), 32'd0);
      @(negedge clk);
      check("one_valid_drop", 32'(valid8), 32'd0);
      check("one_busy_idle", 32'(busy8), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_reducer.md
OPERAND_REDUCER -- requirements
Module: operand_reducer

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits, at least 1.
REQ-002 Parameter NUM_OPS, default 6: operands per packed input word, at least 1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inputs  input  WIDTH*NUM_OPS  packed operands; operand k occupies bits [k*WIDTH +: WIDTH], operand 0 in the LSBs.
REQ-006 mode  input  2  operation select: 00 add, 01 subtract, 10 unsigned min, 11 unsigned max.
REQ-007 start  input  1  request a reduction; sampled only in IDLE.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 out  output  WIDTH  registered result; holds until the next DONE or reset.
REQ-010 valid  output  1  one-cycle pulse marking a new result on out.
REQ-011 ovf  output  1  sticky carry/borrow flag for the current result (see Configuration).

Function
REQ-012 FSM states: IDLE, RUN and DONE; reset forces IDLE.
REQ-013 IDLE with start=1 at edge E0: capture inputs and mode into internal registers; acc <= operand 0; idx <= 1; ovf <= 0.
REQ-014 At E0, next state is RUN if NUM_OPS>1, otherwise DONE with out <= operand 0.
REQ-015 RUN, each edge: acc <= f(acc, operand[idx]) using the captured mode; idx <= idx+1.
REQ-016 RUN, the edge processing idx=NUM_OPS-1 also loads out <= the f result and enters DONE.
REQ-017 valid=1 for exactly the DONE cycle; DONE -> IDLE unconditionally on the next edge.
REQ-018 Latency: valid is high in the cycle after edge E(NUM_OPS-1); for NUM_OPS=1 it is the cycle after E0.
REQ-019 Add and subtract wrap modulo 2^WIDTH; min and max compare unsigned.
REQ-020 Subtract is left-fold: ((op0-op1)-op2)-...
REQ-021 start is ignored in RUN and DONE; no queuing.
REQ-022 Changes to inputs or mode after E0 do not affect the result in flight.
REQ-023 Back-to-back operation: start asserted in the first IDLE cycle after DONE is accepted; the minimum start-to-start spacing is NUM_OPS+1 cycles.
REQ-024 Internal idx is $clog2(NUM_OPS+1) bits wide and never exceeds NUM_OPS-1 while in RUN.

Reset
REQ-025 reset=1 immediately, without waiting for a clock edge: state=IDLE, out=0, valid=0, busy=0, ovf=0, acc=0, idx=0.
REQ-026 Reset during RUN or DONE discards the operation; no valid pulse follows.
REQ-027 After reset deasserts, the first start is accepted normally.

Configuration
REQ-028 Macro REDUCER_OVF_EN defined: ovf sets on an add carry-out or a subtract borrow at any step, and stays set until the next E0 or reset.
REQ-029 With REDUCER_OVF_EN defined, ovf is updated together with out and stays 0 in min and max modes.
REQ-030 Macro REDUCER_OVF_EN undefined: ovf is tied to 0 and no carry or borrow logic is generated; the port remains present.

Structure
REQ-031 Package reducer_pkg holds the mode enum (MODE_ADD, MODE_SUB, MODE_MIN, MODE_MAX) and the state enum (IDLE, RUN, DONE).
REQ-032 Sub-module reducer_alu is purely combinational, parametrised by WIDTH.
REQ-033 reducer_alu computes f(acc, operand, mode) and a carry/borrow bit; the FSM, registers and index live in operand_reducer.

Verification
REQ-034 WIDTH=4, NUM_OPS=6, inputs {1,5,3,12,2,6} (op0=6 ... op5=1), mode=00, start -> valid in the 5th cycle after E0, out=13, ovf=1 (with REDUCER_OVF_EN).
REQ-035 Same operands, mode=01 -> out=15, ovf=1; mode=10 -> out=1, ovf=0; mode=11 -> out=12, ovf=0.
REQ-036 Sequence: start, then reset asserted 2 cycles later for 1 cycle, then start with mode=11 -> no valid pulse for the first start; second start yields out=12; out=0 in between.
REQ-037 Start held high continuously, with inputs changed after E0 -> each result reflects the operands captured at its own E0; valid pulses are exactly 7 cycles apart.
REQ-038 NUM_OPS=1, WIDTH=8, inputs=0xA5, start -> valid in the cycle after E0, out=0xA5, ovf=0.
REQ-039 Build without REDUCER_OVF_EN, add mode, operands summing past 15 -> ovf stays 0 and out is unchanged from the REQ-034 result.
